// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in serial-out transmitter with valid, done and back-to-back reload
module piso_shift_tx #(
  parameter int WIDTH = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             ck,
  input  logic             res,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             en,
  output logic             ready,
  output logic             q,
  output logic             q_valid,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [CW-1:0] cnt, cnt_nx;
  assign done = state == SHIFT && cnt == LAST && en;
  assign ready = state == IDLE || done;
  assign q_valid = state == SHIFT;
  assign q = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
  always_ff @(posedge ck) begin
    if (res) begin
      state <= IDLE;
      sreg <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      sreg <= sreg_nx;
      cnt <= cnt_nx;
    end
  end
  // ready doubles as the accept condition, so a load on the last bit reloads with no gap
  always_comb begin
    state_nx = state;
    sreg_nx = sreg;
    cnt_nx = cnt;
    if (ready && load) begin
      state_nx = SHIFT;
      sreg_nx = din;
      cnt_nx = '0;
    end else if (done) begin
      state_nx = IDLE;
      sreg_nx = '0;
      cnt_nx = '0;
    end else if (state == SHIFT && en) begin
      sreg_nx = (MSB_FIRST != 0) ? sreg << 1 : sreg >> 1;
      cnt_nx = cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: directed checks of an MSB-first and an LSB-first 4-bit transmitter
module tb_piso_shift_tx;
  logic ck = 1'b0, res = 1'b1, load = 1'b0, en = 1'b0;
  logic [3:0] din = '0;
  logic ready_m, q_m, qv_m, done_m;
  logic ready_l, q_l, qv_l, done_l;
  int checks = 0, errors = 0;
  always #5 ck = ~ck;
  piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .ck(ck), .res(res), .din(din), .load(load), .en(en),
    .ready(ready_m), .q(q_m), .q_valid(qv_m), .done(done_m)
  );
  piso_shift_tx #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .ck(ck), .res(res), .din(din), .load(load), .en(en),
    .ready(ready_l), .q(q_l), .q_valid(qv_l), .done(done_l)
  );
  task automatic tick;
    @(posedge ck);
    #1;
  endtask
  task automatic test_reset;
    res = 1'b1;
    tick();
    tick();
    res = 1'b0;
    checks++;
    if ({q_m, qv_m, done_m, ready_m} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_msb {q,qv,done,ready} got %b want 0001", {q_m, qv_m, done_m, ready_m});
    end
    checks++;
    if ({q_l, qv_l, done_l, ready_l} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_lsb {q,qv,done,ready} got %b want 0001", {q_l, qv_l, done_l, ready_l});
    end
  endtask
  task automatic test_single;
    logic [3:0] e;
    e = 4'b1011;
    din = 4'b1011;
    load = 1'b1;
    en = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({q_m, qv_m, done_m} !== {e[3-i], 1'b1, i == 3}) begin
        errors++;
        $display("FAIL single bit%0d {q,qv,done} got %b want %b", i, {q_m, qv_m, done_m}, {e[3-i], 1'b1, i == 3});
      end
      tick();
    end
    checks++;
    if ({q_m, qv_m, done_m, ready_m} !== 4'b0001) begin
      errors++;
      $display("FAIL single_idle {q,qv,done,ready} got %b want 0001", {q_m, qv_m, done_m, ready_m});
    end
  endtask
  task automatic test_lsb_first;
    logic [3:0] e;
    e = 4'b1011;
    din = 4'b1011;
    load = 1'b1;
    en = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({q_l, qv_l, done_l} !== {e[i], 1'b1, i == 3}) begin
        errors++;
        $display("FAIL lsb bit%0d {q,qv,done} got %b want %b", i, {q_l, qv_l, done_l}, {e[i], 1'b1, i == 3});
      end
      tick();
    end
    checks++;
    if ({q_l, qv_l, done_l, ready_l} !== 4'b0001) begin
      errors++;
      $display("FAIL lsb_idle {q,qv,done,ready} got %b want 0001", {q_l, qv_l, done_l, ready_l});
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] e;
    e = 8'b1100_0101;
    din = 4'b1100;
    load = 1'b1;
    en = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        load = 1'b1;
        din = 4'b0101;
      end
      checks++;
      if ({q_m, qv_m, done_m} !== {e[7-i], 1'b1, i == 3 || i == 7}) begin
        errors++;
        $display("FAIL b2b bit%0d {q,qv,done} got %b want %b", i, {q_m, qv_m, done_m}, {e[7-i], 1'b1, i == 3 || i == 7});
      end
      tick();
      load = 1'b0;
    end
    checks++;
    if ({q_m, qv_m, done_m, ready_m} !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_idle {q,qv,done,ready} got %b want 0001", {q_m, qv_m, done_m, ready_m});
    end
  endtask
  task automatic test_stall;
    din = 4'b1001;
    load = 1'b1;
    en = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if ({q_m, qv_m, done_m} !== 3'b110) begin
      errors++;
      $display("FAIL stall bit0 got %b want 110", {q_m, qv_m, done_m});
    end
    tick();
    checks++;
    if ({q_m, qv_m, done_m} !== 3'b010) begin
      errors++;
      $display("FAIL stall bit1 got %b want 010", {q_m, qv_m, done_m});
    end
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({q_m, qv_m, done_m} !== 3'b010) begin
        errors++;
        $display("FAIL stall hold%0d got %b want 010", i, {q_m, qv_m, done_m});
      end
      tick();
    end
    en = 1'b1;
    checks++;
    if ({q_m, qv_m, done_m} !== 3'b010) begin
      errors++;
      $display("FAIL stall bit2 got %b want 010", {q_m, qv_m, done_m});
    end
    tick();
    checks++;
    if ({q_m, qv_m, done_m} !== 3'b111) begin
      errors++;
      $display("FAIL stall bit3 got %b want 111", {q_m, qv_m, done_m});
    end
    tick();
    checks++;
    if ({q_m, qv_m, done_m, ready_m} !== 4'b0001) begin
      errors++;
      $display("FAIL stall_idle got %b want 0001", {q_m, qv_m, done_m, ready_m});
    end
  endtask
  task automatic test_load_busy;
    logic [3:0] e;
    e = 4'b1000;
    din = 4'b1000;
    load = 1'b1;
    en = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        load = 1'b1;
        din = 4'b1111;
        checks++;
        if (ready_m !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready got %b want 0", ready_m);
        end
      end
      checks++;
      if ({q_m, qv_m, done_m} !== {e[3-i], 1'b1, i == 3}) begin
        errors++;
        $display("FAIL busy bit%0d got %b want %b", i, {q_m, qv_m, done_m}, {e[3-i], 1'b1, i == 3});
      end
      tick();
      load = 1'b0;
    end
    checks++;
    if ({q_m, qv_m, done_m, ready_m} !== 4'b0001) begin
      errors++;
      $display("FAIL busy_idle got %b want 0001", {q_m, qv_m, done_m, ready_m});
    end
  endtask
  task automatic test_reset_mid_word;
    logic [3:0] e;
    din = 4'b1011;
    load = 1'b1;
    en = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    checks++;
    if ({q_m, qv_m, done_m} !== 3'b110) begin
      errors++;
      $display("FAIL rst_mid bit2 got %b want 110", {q_m, qv_m, done_m});
    end
    res = 1'b1;
    tick();
    res = 1'b0;
    checks++;
    if ({q_m, qv_m, done_m, ready_m} !== 4'b0001) begin
      errors++;
      $display("FAIL rst_mid_idle got %b want 0001", {q_m, qv_m, done_m, ready_m});
    end
    e = 4'b0110;
    din = 4'b0110;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({q_m, qv_m, done_m} !== {e[3-i], 1'b1, i == 3}) begin
        errors++;
        $display("FAIL rst_mid_next bit%0d got %b want %b", i, {q_m, qv_m, done_m}, {e[3-i], 1'b1, i == 3});
      end
      tick();
    end
    checks++;
    if ({q_m, qv_m, done_m, ready_m} !== 4'b0001) begin
      errors++;
      $display("FAIL rst_mid_final got %b want 0001", {q_m, qv_m, done_m, ready_m});
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_lsb_first();
    test_back_to_back();
    test_stall();
    test_load_busy();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
- Parallel-in / serial-out shift transmitter: the sending end for the team's serial-in shift registers.
- Captures a WIDTH-bit word on a load handshake and emits it one bit per enabled clock on a single serial line, with a valid qualifier and an end-of-word pulse.
- Supports back-to-back words with no gap cycle.

Parameters:
- WIDTH, 4, number of bits per word (WIDTH >= 2).
- MSB_FIRST, 1, 1 = send din[WIDTH-1] first; 0 = send din[0] first.

Ports:
- ck  input  1  clock; all state updates on posedge.
- res  input  1  synchronous reset, active-high.
- din  input  WIDTH  parallel word to transmit.
- load  input  1  request to accept din; honoured only when ready=1.
- en  input  1  shift enable; the bit on q advances only when en=1.
- ready  output  1  block can accept a word this cycle (combinational).
- q  output  1  serial data bit (driven from a register).
- q_valid  output  1  q carries a word bit this cycle.
- done  output  1  one-cycle pulse while the final bit of a word is being consumed (combinational).

Behaviour:
- Reset: on a posedge with res=1, the block goes IDLE. Shift register = 0, bit counter cnt = 0. Outputs: q=0, q_valid=0, done=0, ready=1.
- res has priority over load and en.
- Reset mid-word aborts the word; no done pulse is produced for it.
- State: two states, IDLE and SHIFT (busy flag). Also a WIDTH-bit shift register sreg and a counter cnt of width clog2(WIDTH).
- Outputs per state:
  - q_valid = 1 in SHIFT, 0 in IDLE.
  - q = sreg[WIDTH-1] if MSB_FIRST, else sreg[0].
  - In IDLE, sreg = 0, so q = 0.
- ready = IDLE OR (SHIFT AND cnt==WIDTH-1 AND en).
- done = SHIFT AND cnt==WIDTH-1 AND en.
- IDLE -> SHIFT: on a posedge with load=1:
  - sreg <= din, cnt <= 0.
  - The first bit appears on q the cycle after the load edge (latency 1).
  - en is not required for the load to be accepted.
- In SHIFT, posedge with en=0: hold everything (sreg, cnt, q); q_valid stays 1.
- In SHIFT, posedge with en=1 and cnt<WIDTH-1:
  - sreg shifts toward the output end with 0 fill: left if MSB_FIRST, right otherwise.
  - cnt <= cnt+1.
- In SHIFT, posedge with en=1 and cnt==WIDTH-1 (last bit):
  - If load=1: reload sreg <= din, cnt <= 0, stay in SHIFT. This is back-to-back operation with no idle bit between words.
  - Else: sreg <= 0, cnt <= 0, go to IDLE.
- load while ready=0 is ignored entirely; din is not sampled.
- Each word produces exactly WIDTH cycles with q_valid=1 and en=1, and exactly one done pulse.
- cnt never exceeds WIDTH-1; there is no wrap-around beyond the word length.

Test Plan:
- Single word:
  - Stimulus: WIDTH=4, MSB_FIRST=1, en=1, din=4'b1011, load pulsed 1 cycle.
  - Response: q = 1,0,1,1 on the 4 cycles after the load edge; q_valid high for exactly those 4 cycles; done high only on the 4th; then q=0, q_valid=0, ready=1.
- LSB-first:
  - Stimulus: MSB_FIRST=0, din=4'b1011.
  - Response: q = 1,1,0,1; same q_valid and done timing as the single-word case.
- Back-to-back:
  - Stimulus: load din=4'b1100, then hold load=1 with din=4'b0101 during the cycle where done=1.
  - Response: q = 1,1,0,0,0,1,0,1 continuously; q_valid never drops across the word boundary; done pulses twice.
- Enable stall:
  - Stimulus: din=4'b1001, en=0 for 3 cycles after the 2nd bit.
  - Response: q holds 0 and q_valid stays 1 for the stall; the sequence then resumes 0,1; done asserts only once en=1 on the last bit.
- Load while busy:
  - Stimulus: load=1 with din=4'b1111 on the 2nd bit of word 4'b1000.
  - Response: ready=0 at that point, the load is ignored, and the output stays 1,0,0,0.
- Reset mid-word:
  - Stimulus: res=1 for 1 cycle during the 3rd bit of 4'b1011.
  - Response: the next cycle shows q=0, q_valid=0, ready=1, and no done pulse. A following load of 4'b0110 then transmits cleanly as 0,1,1,0.
